// File: rtl/key_action_scheduler.sv
// Turns decoded PS/2 key events into a queue of Tetris actions, with typematic
// suppression, horizontal DAS/ARR auto-repeat and soft-drop repeat.
module key_action_scheduler #(
  parameter int DAS_CYCLES  = 17_000_000,
  parameter int ARR_CYCLES  = 5_000_000,
  parameter int SOFT_CYCLES = 5_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       key_event_valid,
  input  logic [7:0] current_scan_code,
  input  logic       current_make_break,
  output logic       action_valid,
  output logic [2:0] action_code,
  input  logic       action_ready,
  output logic [7:0] held_keys,
  output logic       overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int H_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int HW    = $clog2(H_MAX + 1);
  localparam int DW    = $clog2(SOFT_CYCLES + 1);

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_t;
  typedef enum logic {D_IDLE, D_REP} d_state_t;

  h_state_t h_state, h_state_n;
  d_state_t d_state, d_state_n;
  logic          h_dir, h_dir_n;
  logic [HW-1:0] h_cnt, h_cnt_n;
  logic [DW-1:0] d_cnt, d_cnt_n;
  logic          h_pend, d_pend, h_pend_n, d_pend_n;
  logic          h_expire, d_expire, h_req, d_req;

  logic       key_hit;
  logic [2:0] key_code;
  logic       ev_valid, ev_make, ev_break;
  logic       h_new, h_act_break, d_new, d_break;

  logic [2:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        full, empty, rd_en, can_write, wr_en;
  logic [2:0]  wr_code;

  always_comb begin
    key_hit  = 1'b1;
    key_code = 3'd0;
    case (current_scan_code)
      8'h6B:   key_code = 3'd0;
      8'h74:   key_code = 3'd1;
      8'h72:   key_code = 3'd2;
      8'h75:   key_code = 3'd3;
      8'h1A:   key_code = 3'd4;
      8'h29:   key_code = 3'd5;
      8'h21:   key_code = 3'd6;
      8'h76:   key_code = 3'd7;
      default: key_hit  = 1'b0;
    endcase
  end

  // A make of an already-held key is a keyboard typematic repeat and is ignored.
  assign ev_valid    = key_event_valid & key_hit & ~rst & ~flush;
  assign ev_make     = ev_valid & current_make_break & ~held_keys[key_code];
  assign ev_break    = ev_valid & ~current_make_break;
  assign h_new       = ev_make & (key_code[2:1] == 2'b00);
  assign h_act_break = ev_break & (key_code[2:1] == 2'b00) & (h_state != H_IDLE) & (key_code[0] == h_dir);
  assign d_new       = ev_make & (key_code == 3'd2);
  assign d_break     = ev_break & (key_code == 3'd2);

  always_comb begin
    h_state_n = h_state;
    h_dir_n   = h_dir;
    h_cnt_n   = h_cnt;
    h_expire  = 1'b0;
    if (h_new) begin
      h_state_n = H_DAS;
      h_dir_n   = key_code[0];
      h_cnt_n   = HW'(DAS_CYCLES);
    end else if (h_act_break) begin
      if (held_keys[{2'b00, ~h_dir}]) begin
        h_state_n = H_DAS;
        h_dir_n   = ~h_dir;
        h_cnt_n   = HW'(DAS_CYCLES);
      end else begin
        h_state_n = H_IDLE;
        h_cnt_n   = '0;
      end
    end else if (h_state != H_IDLE) begin
      if (h_cnt == HW'(1)) begin
        h_expire  = 1'b1;
        h_state_n = H_ARR;
        h_cnt_n   = HW'(ARR_CYCLES);
      end else begin
        h_cnt_n = h_cnt - HW'(1);
      end
    end
  end

  always_comb begin
    d_state_n = d_state;
    d_cnt_n   = d_cnt;
    d_expire  = 1'b0;
    if (d_new) begin
      d_state_n = D_REP;
      d_cnt_n   = DW'(SOFT_CYCLES);
    end else if (d_break) begin
      d_state_n = D_IDLE;
      d_cnt_n   = '0;
    end else if (d_state == D_REP) begin
      if (d_cnt == DW'(1)) begin
        d_expire = 1'b1;
        d_cnt_n  = DW'(SOFT_CYCLES);
      end else begin
        d_cnt_n = d_cnt - DW'(1);
      end
    end
  end

  // A repeat that loses arbitration stays pending; one that wins on a full queue is dropped.
  always_comb begin
    h_req    = (h_pend & ~h_new & ~h_act_break) | h_expire;
    d_req    = (d_pend & ~d_new & ~d_break) | d_expire;
    wr_code  = 3'd2;
    h_pend_n = 1'b0;
    d_pend_n = 1'b0;
    if (ev_make) begin
      wr_code  = key_code;
      h_pend_n = h_req;
      d_pend_n = d_req;
    end else if (h_req) begin
      wr_code  = {2'b00, h_dir};
      d_pend_n = d_req;
    end
  end

  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign empty        = (wr_ptr == rd_ptr);
  assign action_valid = ~empty;
  assign action_code  = empty ? 3'd0 : mem[rd_ptr[AW-1:0]];
  assign rd_en        = action_valid & action_ready;
  assign can_write    = ~full | rd_en;
  assign wr_en        = (ev_make | h_req | d_req) & can_write & ~rst & ~flush;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_code;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      h_state   <= H_IDLE;
      d_state   <= D_IDLE;
      h_dir     <= 1'b0;
      h_cnt     <= '0;
      d_cnt     <= '0;
      h_pend    <= 1'b0;
      d_pend    <= 1'b0;
      held_keys <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      h_state  <= h_state_n;
      d_state  <= d_state_n;
      h_dir    <= h_dir_n;
      h_cnt    <= h_cnt_n;
      d_cnt    <= d_cnt_n;
      h_pend   <= h_pend_n;
      d_pend   <= d_pend_n;
      overflow <= ev_make & ~can_write;
      if (ev_valid) held_keys[key_code] <= current_make_break;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_key_action_scheduler.sv
// Directed test-plan scenarios plus randomized key traffic, checked every cycle
// against a queue-based model that schedules repeats by absolute cycle number.
module tb_key_action_scheduler;

  localparam int DAS   = 8;
  localparam int ARR   = 3;
  localparam int SOFT  = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, flush, key_event_valid, current_make_break, action_ready;
  logic [7:0] current_scan_code;
  logic       action_valid, overflow;
  logic [2:0] action_code;
  logic [7:0] held_keys;

  int errors = 0;
  int checks = 0;
  int act_seen = 0;
  int ov_seen = 0;

  logic [7:0] scan_tab [8] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h1A, 8'h29, 8'h21, 8'h76};

  // Reference model state
  int         m_q [$];
  logic [7:0] m_held = '0;
  logic       m_ov = 1'b0;
  logic       h_active = 1'b0, d_active = 1'b0, h_pend = 1'b0, d_pend = 1'b0;
  int         h_dir = 0;
  longint     h_fire = 0, d_fire = 0, cyc = 0;

  key_action_scheduler #(
    .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .SOFT_CYCLES(SOFT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .key_event_valid(key_event_valid),
    .current_scan_code(current_scan_code),
    .current_make_break(current_make_break),
    .action_valid(action_valid), .action_code(action_code),
    .action_ready(action_ready), .held_keys(held_keys), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelStep(input logic r, input logic fl, input logic v,
                           input logic [7:0] sc, input logic mb, input logic rdy);
    int   code;
    logic hit, ev_make, ev_break, h_ev, d_ev, h_exp, d_exp, h_req, d_req, space, deq;
    m_ov = 1'b0;
    if (r || fl) begin
      m_q.delete();
      m_held = '0;
      h_active = 1'b0; d_active = 1'b0; h_pend = 1'b0; d_pend = 1'b0;
    end else begin
      hit = 1'b0; code = 0;
      for (int i = 0; i < 8; i++) if (scan_tab[i] == sc) begin hit = 1'b1; code = i; end
      deq      = rdy && (m_q.size() > 0);
      ev_make  = v && hit && mb && !m_held[code];
      ev_break = v && hit && !mb;
      h_ev = 1'b0; d_ev = 1'b0;
      if (ev_make && code < 2) begin
        h_ev = 1'b1; h_active = 1'b1; h_dir = code; h_fire = cyc + DAS;
      end else if (ev_break && h_active && code == h_dir) begin
        h_ev = 1'b1;
        if (m_held[1 - h_dir]) begin h_dir = 1 - h_dir; h_fire = cyc + DAS; end
        else h_active = 1'b0;
      end
      h_exp = !h_ev && h_active && (cyc == h_fire);
      if (h_exp) h_fire = cyc + ARR;
      if (h_ev) h_pend = 1'b0;
      if (ev_make && code == 2) begin
        d_ev = 1'b1; d_active = 1'b1; d_fire = cyc + SOFT;
      end else if (ev_break && code == 2) begin
        d_ev = 1'b1; d_active = 1'b0;
      end
      d_exp = !d_ev && d_active && (cyc == d_fire);
      if (d_exp) d_fire = cyc + SOFT;
      if (d_ev) d_pend = 1'b0;
      if (v && hit) m_held[code] = mb;
      h_req = h_pend || h_exp;
      d_req = d_pend || d_exp;
      space = (m_q.size() < DEPTH) || deq;
      if (deq) void'(m_q.pop_front());
      if (ev_make) begin
        if (space) m_q.push_back(code); else m_ov = 1'b1;
        h_pend = h_req; d_pend = d_req;
      end else if (h_req) begin
        if (space) m_q.push_back(h_dir);
        h_pend = 1'b0; d_pend = d_req;
      end else if (d_req) begin
        if (space) m_q.push_back(2);
        d_pend = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic compareModel();
    checkOutput("valid", action_valid, m_q.size() > 0);
    if (m_q.size() > 0) checkOutput("code", action_code, m_q[0]);
    checkOutput("held", held_keys, m_held);
    checkOutput("overflow", overflow, m_ov);
  endtask

  task automatic applyStimulus(input logic r, input logic fl, input logic v,
                               input logic [7:0] sc, input logic mb, input logic rdy);
    rst = r; flush = fl; key_event_valid = v;
    current_scan_code = sc; current_make_break = mb; action_ready = rdy;
    modelStep(r, fl, v, sc, mb, rdy);
    @(posedge clk);
    #1;
    compareModel();
    if (action_valid) act_seen++;
    if (overflow) ov_seen++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic key(input logic [7:0] sc, input logic mb, input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b1, sc, mb, rdy);
  endtask

  initial begin
    logic [7:0] sc;
    int         idx;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b1);
    checkOutput("rst_valid", action_valid, 0);
    checkOutput("rst_code", action_code, 0);
    checkOutput("rst_held", held_keys, 0);
    checkOutput("rst_overflow", overflow, 0);

    act_seen = 0;
    key(8'h75, 1'b1, 1'b1); idle(9, 1'b1); key(8'h75, 1'b0, 1'b1); idle(5, 1'b1);
    checkOutput("tap_count", act_seen, 1);

    act_seen = 0;
    key(8'h6B, 1'b1, 1'b1); idle(19, 1'b1); key(8'h6B, 1'b0, 1'b1); idle(10, 1'b1);
    checkOutput("das_arr_count", act_seen, 5);

    act_seen = 0;
    key(8'h6B, 1'b1, 1'b1);
    for (int k = 1; k < 20; k++) begin
      if (k % 4 == 0) key(8'h6B, 1'b1, 1'b1); else idle(1, 1'b1);
    end
    key(8'h6B, 1'b0, 1'b1); idle(10, 1'b1);
    checkOutput("typematic_count", act_seen, 5);

    act_seen = 0;
    key(8'h6B, 1'b1, 1'b1); idle(4, 1'b1);
    key(8'h74, 1'b1, 1'b1); idle(6, 1'b1);
    key(8'h74, 1'b0, 1'b1); idle(9, 1'b1);
    key(8'h6B, 1'b0, 1'b1); idle(5, 1'b1);
    checkOutput("switch_count", act_seen, 3);

    ov_seen = 0;
    for (int i = 3; i < 8; i++) key(scan_tab[i], 1'b1, 1'b0);
    for (int i = 3; i < 8; i++) key(scan_tab[i], 1'b0, 1'b0);
    checkOutput("full_valid", action_valid, 1);
    checkOutput("full_head", action_code, 3);
    idle(8, 1'b1);
    checkOutput("overflow_count", ov_seen, 1);

    key(8'h6B, 1'b1, 1'b1); idle(2, 1'b1);
    key(8'h72, 1'b1, 1'b1); idle(11, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_held", held_keys, 0);
    checkOutput("flush_valid", action_valid, 0);
    act_seen = 0;
    idle(20, 1'b1);
    checkOutput("flush_quiet", act_seen, 0);

    for (int n = 0; n < 3000; n++) begin
      idx = $urandom_range(0, 10);
      sc  = (idx >= 8) ? 8'h1C : scan_tab[idx];
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) == 0, sc, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_action_scheduler.md
# key_action_scheduler

Converts decoded PS/2 key events (scan code, make/break, one-cycle valid strobe) into a queue of Tetris game actions for the game-logic FSM. Tracks which mapped keys are held, suppresses keyboard typematic repeats, and generates its own auto-repeat: horizontal DAS/ARR and soft-drop repeat. Arbitrates event-driven and timer-driven actions onto a single FIFO write port. Sits between `ps2_keyboard` and the game controller.

## Interface
- `DAS_CYCLES`, default 17_000_000, delay from horizontal press to first auto-repeat (≥2)
- `ARR_CYCLES`, default 5_000_000, horizontal auto-repeat period (≥1)
- `SOFT_CYCLES`, default 5_000_000, soft-drop repeat period (≥1)
- `FIFO_DEPTH`, default 4, action queue depth (power of two, ≥2)

- `clk` in 1 system clock; single clock domain
- `rst` in 1 synchronous, active-high reset
- `flush` in 1 synchronous clear of queue, held state and timers (game over / restart)
- `key_event_valid` in 1 one-cycle strobe from `ps2_keyboard`
- `current_scan_code` in 8 scan code (E0 prefix already stripped)
- `current_make_break` in 1 1 = press, 0 = release
- `action_valid` out 1 queue head valid
- `action_code` out 3 queue head action
- `action_ready` in 1 consumer accepts head when high with `action_valid`
- `held_keys` out 8 held bitmap indexed by action code
- `overflow` out 1 one-cycle pulse when an event action is dropped on a full queue

## Operation
- Key map (code/scan): 0 LEFT 6B, 1 RIGHT 74, 2 DOWN 72, 3 ROT_CW 75, 4 ROT_CCW 1A, 5 HARD_DROP 29, 6 HOLD 21, 7 PAUSE 76. Unmapped codes are ignored.
- Make of a key whose held bit is already set is a typematic repeat. It is ignored with no action and no timer restart.
- Make of an unheld key sets its held bit and raises an event request for that code. Break clears the held bit and produces no action.
- Horizontal FSM: states H_IDLE, H_DAS, H_ARR, with an active-direction register.
  - A new LEFT/RIGHT make sets the direction to that key, enters H_DAS and loads the DAS counter. Last press wins.
  - In H_DAS, expiry raises a horizontal repeat request and moves to H_ARR. In H_ARR, each expiry raises a request and reloads ARR_CYCLES.
  - Break of the active key with the other key still held: switch direction, re-enter H_DAS, no immediate action.
  - Break of the active key with the other key not held: go to H_IDLE.
  - Break of the inactive key only clears its held bit.
- Down FSM: states D_IDLE, D_REP.
  - DOWN make enters D_REP and loads SOFT_CYCLES. Each expiry raises a down repeat request.
  - DOWN break returns to D_IDLE.
- Write arbitration, one enqueue per cycle, priority: event request > horizontal repeat > down repeat.
  - A losing repeat request stays pending and retries next cycle.
  - A new expiry while a request is still pending merges into it and is never counted twice.
- Full queue:
  - Event action: dropped and `overflow` pulses.
  - Pending repeat: discarded silently. Timers keep running, so no backlog builds up.
- Simultaneous enqueue and dequeue on a full queue succeeds. Occupancy stays unchanged.
- The queue is first-word-fall-through and pointers wrap modulo FIFO_DEPTH.
- `flush` or `rst` clears: queue, pending flags, held bits, both FSMs to idle, counters, `overflow`. A `key_event_valid` in the same cycle is discarded.

## Timing
- Reset values: `action_valid`=0, `action_code`=0, `held_keys`=0, `overflow`=0.
- Event at cycle N into an empty queue gives `action_valid`=1 with that code at N+1. `held_keys` updates at N+1.
- Horizontal make at N: first action at N+1, first repeat visible at N+1+DAS_CYCLES, then every ARR_CYCLES. This holds only if the queue is not full and the repeat wins arbitration.
- DOWN make at N: action at N+1, repeats at N+1+k·SOFT_CYCLES.
- Arbitration loss delays a repeat by one cycle per higher-priority winner. It does not shift the timer phase.
- `overflow` is asserted in the cycle after the dropped event.
- Dequeue: the head advances in the cycle after `action_valid && action_ready`.

## Test plan
- Reset, then tap ROT_CW (make 75, break 75 ten cycles later) → exactly one action 3 at N+1; `held_keys`[3] is high for 10 cycles.
- DAS=8, ARR=3, `action_ready`=1: hold LEFT for 20 cycles → actions 0 at N+1, N+9, N+12, N+15, N+18; none after the break.
- Hold LEFT, press RIGHT at +5, release RIGHT at +12 → RIGHT at +6. LEFT resumes: no immediate action, first LEFT repeat at +12+1+DAS.
- Typematic: LEFT make repeated every 4 cycles while held → no extra actions beyond the DAS/ARR schedule.
- `action_ready`=0, five distinct event makes → four queued in order; the fifth pulses `overflow`. Then `action_ready`=1 drains codes in order.
- Horizontal and down repeats expiring in the same cycle → horizontal enqueued first, down one cycle later. Mid-hold `flush` → queue empty, `held_keys`=0, no further repeats.
